// File: rtl/lsu_dbus_ctrl_pkg.sv
// Shared LSU data-bus definitions: load/store op codes, controller states,
// access sizes, bus request payload and byte-enable helpers.
package lsu_dbus_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned SEL_W = XLEN / 8;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LH   = 3'd2,
      LD_LW   = 3'd3,
      LD_LBU  = 3'd4,
      LD_LHU  = 3'd5
   } type_ld_ops_e;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_SB   = 2'd1,
      ST_SH   = 2'd2,
      ST_SW   = 2'd3
   } type_st_ops_e;

   typedef enum logic [1:0] {
      DBUS_IDLE  = 2'd0,
      DBUS_BUSY  = 2'd1,
      DBUS_DRAIN = 2'd2
   } type_dbus_states_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } type_size_e;

   typedef struct packed {
      logic             w_en;
      logic [XLEN-1:0]  addr;
      logic [SEL_W-1:0] sel;
      logic [XLEN-1:0]  w_data;
   } type_dbus_req_s;

   function automatic type_size_e ld_size(input type_ld_ops_e op);
      case (op)
         LD_LB, LD_LBU: return SZ_B;
         LD_LH, LD_LHU: return SZ_H;
         default:       return SZ_W;
      endcase
   endfunction

   function automatic type_size_e st_size(input type_st_ops_e op);
      case (op)
         ST_SB:   return SZ_B;
         ST_SH:   return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

   function automatic logic [SEL_W-1:0] size_sel(input type_size_e sz, input logic [1:0] off);
      case (sz)
         SZ_B:    return SEL_W'(4'b0001 << off);
         SZ_H:    return SEL_W'(4'b0011 << {off[1], 1'b0});
         default: return '1;
      endcase
   endfunction

   function automatic logic is_misaligned(input type_size_e sz, input logic [1:0] off);
      case (sz)
         SZ_H:    return off[0];
         SZ_W:    return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_ld_fmt.sv
// Load result formatter: aligns the addressed lane of a bus word and
// sign/zero-extends it according to the load op.
module lsu_ld_fmt
   import lsu_dbus_ctrl_pkg::*;
(
   input  logic [XLEN-1:0] r_data_i,
   input  logic [1:0]      off_i,
   input  type_ld_ops_e    ld_op_i,
   output logic [XLEN-1:0] r_data_o
);

   logic [XLEN-1:0] shifted;

   always_comb begin
      shifted = r_data_i >> {off_i, 3'b000};
      case (ld_op_i)
         LD_LB:   r_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         LD_LH:   r_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         LD_LBU:  r_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
         LD_LHU:  r_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: r_data_o = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_dbus_ctrl.sv
// Data-bus request controller: arbitrates LSU and AMO accesses, holds each
// request on the bus until ack, formats load data, handles flush and timeout.
module lsu_dbus_ctrl
   import lsu_dbus_ctrl_pkg::*;
#(
   parameter int unsigned BUS_TIMEOUT = 255
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld_req_i,
   input  logic             st_req_i,
   input  logic [2:0]       ld_ops_i,
   input  logic [1:0]       st_ops_i,
   input  logic [XLEN-1:0]  addr_i,
   input  logic [XLEN-1:0]  w_data_i,
   input  logic             amo_ld_req_i,
   input  logic             amo_st_req_i,
   input  logic [XLEN-1:0]  amo_w_data_i,
   input  logic             flush_i,
   output logic             dbus_req_o,
   output logic             dbus_w_en_o,
   output logic [XLEN-1:0]  dbus_addr_o,
   output logic [SEL_W-1:0] dbus_sel_o,
   output logic [XLEN-1:0]  dbus_w_data_o,
   input  logic             dbus_ack_i,
   input  logic [XLEN-1:0]  dbus_r_data_i,
   output logic             ack_o,
   output logic [XLEN-1:0]  r_data_o,
   output logic             misalign_o,
   output logic             bus_err_o
);

   localparam int unsigned CNT_W   = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
   localparam int unsigned TO_LAST = (BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1;
   localparam bit          TO_EN   = (BUS_TIMEOUT != 0);

   type_dbus_states_e state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   type_dbus_req_s    pay_q, pay_d;
   type_ld_ops_e      ld_op_q, ld_op_d;
   logic [1:0]        off_q, off_d;
   logic              req_q, req_d;
   logic              bus_err_q, bus_err_d;

   logic              req_vld;
   logic              req_w_en;
   type_size_e        req_size;
   type_ld_ops_e      req_ld_op;
   logic [XLEN-1:0]   req_w_raw;
   logic [XLEN-1:0]   req_w_data;
   logic              req_mis;
   logic [CNT_W-1:0]  cnt_inc;
   logic              timeout_hit;
   logic [XLEN-1:0]   fmt_data;

   // Request arbitration: amo_st > amo_ld > st > ld; AMO is always a full word.
   always_comb begin
      req_vld   = 1'b1;
      req_w_en  = 1'b0;
      req_size  = SZ_W;
      req_ld_op = LD_LW;
      req_w_raw = w_data_i;
      if (amo_st_req_i) begin
         req_w_en  = 1'b1;
         req_w_raw = amo_w_data_i;
      end else if (amo_ld_req_i) begin
         req_w_en  = 1'b0;
      end else if (st_req_i) begin
         req_w_en  = 1'b1;
         req_size  = st_size(type_st_ops_e'(st_ops_i));
      end else if (ld_req_i) begin
         req_size  = ld_size(type_ld_ops_e'(ld_ops_i));
         req_ld_op = type_ld_ops_e'(ld_ops_i);
      end else begin
         req_vld   = 1'b0;
      end
      case (req_size)
         SZ_B:    req_w_data = {(XLEN/8){req_w_raw[7:0]}};
         SZ_H:    req_w_data = {(XLEN/16){req_w_raw[15:0]}};
         default: req_w_data = req_w_raw;
      endcase
      req_mis = is_misaligned(req_size, addr_i[1:0]);
   end

   assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
   assign timeout_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pay_d      = pay_q;
      ld_op_d    = ld_op_q;
      off_d      = off_q;
      req_d      = req_q;
      bus_err_d  = 1'b0;
      ack_o      = 1'b0;
      misalign_o = 1'b0;
      case (state_q)
         DBUS_IDLE: begin
            misalign_o = req_vld & req_mis;
            if (req_vld && !req_mis && !flush_i) begin
               state_d      = DBUS_BUSY;
               req_d        = 1'b1;
               cnt_d        = '0;
               pay_d.w_en   = req_w_en;
               pay_d.addr   = {addr_i[XLEN-1:2], 2'b00};
               pay_d.sel    = size_sel(req_size, addr_i[1:0]);
               pay_d.w_data = req_w_data;
               ld_op_d      = req_ld_op;
               off_d        = addr_i[1:0];
            end
         end
         DBUS_BUSY: begin
            cnt_d = cnt_inc;
            // A flush coinciding with the ack still completes the bus beat but drops the result.
            if (dbus_ack_i) begin
               state_d = DBUS_IDLE;
               req_d   = 1'b0;
               ack_o   = !flush_i;
            end else if (flush_i) begin
               state_d = DBUS_DRAIN;
            end else if (timeout_hit) begin
               state_d   = DBUS_IDLE;
               req_d     = 1'b0;
               bus_err_d = 1'b1;
            end
         end
         DBUS_DRAIN: begin
            cnt_d = cnt_inc;
            if (dbus_ack_i || timeout_hit) begin
               state_d = DBUS_IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = DBUS_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= DBUS_IDLE;
         cnt_q     <= '0;
         pay_q     <= '0;
         ld_op_q   <= LD_NONE;
         off_q     <= '0;
         req_q     <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pay_q     <= pay_d;
         ld_op_q   <= ld_op_d;
         off_q     <= off_d;
         req_q     <= req_d;
         bus_err_q <= bus_err_d;
      end
   end

   lsu_ld_fmt u_ld_fmt (
      .r_data_i (dbus_r_data_i),
      .off_i    (off_q),
      .ld_op_i  (ld_op_q),
      .r_data_o (fmt_data)
   );

   assign dbus_req_o    = req_q;
   assign dbus_w_en_o   = pay_q.w_en;
   assign dbus_addr_o   = pay_q.addr;
   assign dbus_sel_o    = pay_q.sel;
   assign dbus_w_data_o = pay_q.w_data;
   assign bus_err_o     = bus_err_q;
   assign r_data_o      = ack_o ? fmt_data : '0;

endmodule

// File: tb/tb_lsu_dbus_ctrl.sv
// Self-checking bench for lsu_dbus_ctrl: directed scenarios plus randomized
// transfers compared against an arithmetic reference model.
module tb_lsu_dbus_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_req_i, st_req_i, amo_ld_req_i, amo_st_req_i, flush_i;
   logic [2:0]  ld_ops_i;
   logic [1:0]  st_ops_i;
   logic [31:0] addr_i, w_data_i, amo_w_data_i;
   logic        dbus_ack_i;
   logic [31:0] dbus_r_data_i;

   logic        dbus_req_o, dbus_w_en_o, ack_o, misalign_o, bus_err_o;
   logic [31:0] dbus_addr_o, dbus_w_data_o, r_data_o;
   logic [3:0]  dbus_sel_o;

   logic        to_req, to_w_en, to_ack, to_mis, to_err;
   logic [31:0] to_addr, to_w_data, to_r_data;
   logic [3:0]  to_sel;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_dbus_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .ld_req_i(ld_req_i), .st_req_i(st_req_i),
      .ld_ops_i(ld_ops_i), .st_ops_i(st_ops_i), .addr_i(addr_i), .w_data_i(w_data_i),
      .amo_ld_req_i(amo_ld_req_i), .amo_st_req_i(amo_st_req_i), .amo_w_data_i(amo_w_data_i),
      .flush_i(flush_i), .dbus_req_o(dbus_req_o), .dbus_w_en_o(dbus_w_en_o),
      .dbus_addr_o(dbus_addr_o), .dbus_sel_o(dbus_sel_o), .dbus_w_data_o(dbus_w_data_o),
      .dbus_ack_i(dbus_ack_i), .dbus_r_data_i(dbus_r_data_i), .ack_o(ack_o),
      .r_data_o(r_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   lsu_dbus_ctrl #(.BUS_TIMEOUT(4)) u_dut_to (
      .clk(clk), .rst_n(rst_n), .ld_req_i(ld_req_i), .st_req_i(st_req_i),
      .ld_ops_i(ld_ops_i), .st_ops_i(st_ops_i), .addr_i(addr_i), .w_data_i(w_data_i),
      .amo_ld_req_i(amo_ld_req_i), .amo_st_req_i(amo_st_req_i), .amo_w_data_i(amo_w_data_i),
      .flush_i(flush_i), .dbus_req_o(to_req), .dbus_w_en_o(to_w_en),
      .dbus_addr_o(to_addr), .dbus_sel_o(to_sel), .dbus_w_data_o(to_w_data),
      .dbus_ack_i(dbus_ack_i), .dbus_r_data_i(dbus_r_data_i), .ack_o(to_ack),
      .r_data_o(to_r_data), .misalign_o(to_mis), .bus_err_o(to_err)
   );

   // Reference model. kind: 0 ld, 1 st, 2 amo_ld, 3 amo_st.
   function automatic int ref_size(input int kind, input int op);
      if (kind >= 2) return 4;
      if (kind == 1) return (op == 3) ? 4 : op;
      if (op == 1 || op == 4) return 1;
      if (op == 2 || op == 5) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] ref_sel(input int sz, input logic [31:0] a);
      int v;
      v = ((1 << sz) - 1) << (a % 4);
      return 4'(v);
   endfunction

   function automatic logic [31:0] ref_wdata(input int sz, input logic [31:0] w);
      if (sz == 1) return (w % 256) * 32'h0101_0101;
      if (sz == 2) return (w % 65536) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] ref_rdata(input int kind, input int op, input logic [31:0] a,
                                             input logic [31:0] r);
      longint unsigned v, span;
      int sz;
      sz   = ref_size(kind, op);
      span = 64'd1 << (8 * sz);
      v    = (64'(r) >> (8 * (a % 4))) % span;
      if (kind == 0 && (op == 1 || op == 2) && v >= span / 2) v = v + (64'h1_0000_0000 - span);
      return 32'(v);
   endfunction

   task automatic drop_reqs();
      ld_req_i = 1'b0; st_req_i = 1'b0; amo_ld_req_i = 1'b0; amo_st_req_i = 1'b0;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      drop_reqs();
      flush_i = 1'b0; dbus_ack_i = 1'b0; dbus_r_data_i = '0;
      ld_ops_i = '0; st_ops_i = '0; addr_i = '0; w_data_i = '0; amo_w_data_i = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Bus-side driver: waits for the issue, holds off ack for wait_n cycles, then acks.
   task automatic run_xfer(input int wait_n, input logic [31:0] rdata, output int lat,
                           output logic [3:0] sel, output logic [31:0] addr,
                           output logic [31:0] wdata, output logic wen, output logic [31:0] rd,
                           output int acks, output bit stable);
      lat = 0; acks = 0; stable = 1'b1; rd = '0;
      sel = '0; addr = '0; wdata = '0; wen = 1'b0;
      while (dbus_req_o !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      if (dbus_req_o !== 1'b1) return;
      sel = dbus_sel_o; addr = dbus_addr_o; wdata = dbus_w_data_o; wen = dbus_w_en_o;
      for (int i = 0; i < wait_n; i++) begin
         #1;
         if (ack_o === 1'b1) acks++;
         @(posedge clk); #1;
         if (dbus_req_o !== 1'b1 || dbus_sel_o !== sel || dbus_addr_o !== addr ||
             dbus_w_data_o !== wdata || dbus_w_en_o !== wen) stable = 1'b0;
      end
      dbus_ack_i = 1'b1; dbus_r_data_i = rdata;
      #1;
      if (ack_o === 1'b1) begin
         acks++;
         rd = r_data_o;
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0; dbus_r_data_i = '0;
      #1;
      if (ack_o === 1'b1) acks++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drop_reqs();
      flush_i = 1'b0; dbus_ack_i = 1'b0; dbus_r_data_i = '0;
      ld_ops_i = '0; st_ops_i = '0; addr_i = '0; w_data_i = '0; amo_w_data_i = '0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if ({dbus_req_o, dbus_w_en_o, dbus_addr_o, dbus_sel_o, dbus_w_data_o, ack_o, r_data_o,
           misalign_o, bus_err_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: req=%b wen=%b addr=%h sel=%b wd=%h ack=%b rd=%h mis=%b err=%b, all required 0",
                  dbus_req_o, dbus_w_en_o, dbus_addr_o, dbus_sel_o, dbus_w_data_o, ack_o,
                  r_data_o, misalign_o, bus_err_o);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      dbus_ack_i = 1'b1; dbus_r_data_i = 32'hFFFF_FFFF;
      #1;
      n_tests++;
      if (ack_o !== 1'b0 || r_data_o !== 32'h0) begin
         n_fail++;
         $display("FAIL idle_stray_ack: ack_o=%b r_data_o=%h, required 0/0", ack_o, r_data_o);
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0; dbus_r_data_i = '0;
      n_tests++;
      if (dbus_req_o !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req: dbus_req_o=%b required 0", dbus_req_o);
      end
   endtask

   task automatic test_lb();
      int lat, acks; logic [3:0] sel; logic [31:0] a, wd, rd; logic wen; bit st;
      ld_req_i = 1'b1; ld_ops_i = 3'd1; addr_i = 32'h0000_1003;
      run_xfer(2, 32'h80AA_BBCC, lat, sel, a, wd, wen, rd, acks, st);
      drop_reqs();
      n_tests++;
      if (lat !== 1) begin n_fail++; $display("FAIL lb_latency: got %0d required 1", lat); end
      n_tests++;
      if (sel !== 4'b1000 || a !== 32'h0000_1000 || wen !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_bus: sel=%b addr=%h wen=%b required 1000/00001000/0", sel, a, wen);
      end
      n_tests++;
      if (rd !== 32'hFFFF_FF80 || acks !== 1 || st !== 1'b1) begin
         n_fail++;
         $display("FAIL lb_result: r_data=%h acks=%0d stable=%b required ffffff80/1/1", rd, acks, st);
      end
   endtask

   task automatic test_sh();
      int lat, acks; logic [3:0] sel; logic [31:0] a, wd, rd; logic wen; bit st; int extra;
      st_req_i = 1'b1; st_ops_i = 2'd2; addr_i = 32'h0000_2002; w_data_i = 32'h1234_ABCD;
      run_xfer(1, 32'h5555_AAAA, lat, sel, a, wd, wen, rd, acks, st);
      drop_reqs();
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (dbus_req_o === 1'b1 || ack_o === 1'b1) extra++;
      end
      n_tests++;
      if (sel !== 4'b1100 || wd !== 32'hABCD_ABCD || wen !== 1'b1 || a !== 32'h0000_2000) begin
         n_fail++;
         $display("FAIL sh_bus: sel=%b wd=%h wen=%b addr=%h required 1100/abcdabcd/1/00002000",
                  sel, wd, wen, a);
      end
      n_tests++;
      if (acks !== 1 || extra !== 0 || st !== 1'b1) begin
         n_fail++;
         $display("FAIL sh_single: acks=%0d extra=%0d stable=%b required 1/0/1", acks, extra, st);
      end
   endtask

   task automatic test_amo();
      int lat, acks; logic [3:0] sel; logic [31:0] a, wd, rd; logic wen; bit st;
      st_req_i = 1'b1; st_ops_i = 2'd1; w_data_i = 32'hDEAD_BEEF;
      amo_ld_req_i = 1'b1; addr_i = 32'h0000_3000;
      run_xfer(1, 32'h0000_0005, lat, sel, a, wd, wen, rd, acks, st);
      n_tests++;
      if (wen !== 1'b0 || sel !== 4'hF || rd !== 32'h5 || acks !== 1) begin
         n_fail++;
         $display("FAIL amo_ld: wen=%b sel=%b rd=%h acks=%0d required 0/1111/5/1", wen, sel, rd, acks);
      end
      amo_ld_req_i = 1'b0; amo_st_req_i = 1'b1; amo_w_data_i = 32'h0000_0007;
      run_xfer(0, 32'h0, lat, sel, a, wd, wen, rd, acks, st);
      drop_reqs();
      n_tests++;
      if (wen !== 1'b1 || sel !== 4'hF || wd !== 32'h7 || acks !== 1 || a !== 32'h0000_3000) begin
         n_fail++;
         $display("FAIL amo_st: wen=%b sel=%b wd=%h acks=%0d addr=%h required 1/1111/7/1/00003000",
                  wen, sel, wd, acks, a);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_misalign();
      bit mis_ok, quiet;
      ld_req_i = 1'b1; ld_ops_i = 3'd3; addr_i = 32'h0000_4001;
      mis_ok = 1'b1; quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (misalign_o !== 1'b1) mis_ok = 1'b0;
         if (dbus_req_o !== 1'b0 || ack_o !== 1'b0) quiet = 1'b0;
         @(posedge clk); #1;
      end
      n_tests++;
      if (mis_ok !== 1'b1 || quiet !== 1'b1) begin
         n_fail++;
         $display("FAIL lw_misalign: misalign_held=%b bus_quiet=%b required 1/1", mis_ok, quiet);
      end
      ld_ops_i = 3'd5; addr_i = 32'h0000_4003;
      #1;
      n_tests++;
      if (misalign_o !== 1'b1) begin
         n_fail++; $display("FAIL lhu_misalign: misalign_o=%b required 1", misalign_o);
      end
      flush_i = 1'b1; ld_ops_i = 3'd2; addr_i = 32'h0000_4002;
      #1;
      n_tests++;
      if (misalign_o !== 1'b0) begin
         n_fail++; $display("FAIL lh_aligned: misalign_o=%b required 0", misalign_o);
      end
      ld_req_i = 1'b0; st_req_i = 1'b1; st_ops_i = 2'd1; addr_i = 32'h0000_4003;
      #1;
      n_tests++;
      if (misalign_o !== 1'b0) begin
         n_fail++; $display("FAIL sb_any_addr: misalign_o=%b required 0", misalign_o);
      end
      @(posedge clk); #1;
      n_tests++;
      if (dbus_req_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_blocks_issue: dbus_req_o=%b required 0", dbus_req_o);
      end
      drop_reqs(); flush_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      bit held;
      ld_req_i = 1'b1; ld_ops_i = 3'd3; addr_i = 32'h0000_5000;
      @(posedge clk); #1;
      n_tests++;
      if (dbus_req_o !== 1'b1) begin
         n_fail++; $display("FAIL flush_issue: dbus_req_o=%b required 1", dbus_req_o);
      end
      flush_i = 1'b1; ld_req_i = 1'b0;
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (ack_o !== 1'b0) held = 1'b0;
         @(posedge clk); #1;
         flush_i = 1'b0;
         if (dbus_req_o !== 1'b1) held = 1'b0;
      end
      dbus_ack_i = 1'b1; dbus_r_data_i = 32'h1111_2222;
      #1;
      if (ack_o !== 1'b0 || r_data_o !== 32'h0) held = 1'b0;
      n_tests++;
      if (held !== 1'b1) begin
         n_fail++; $display("FAIL drain_hold: req_held_no_ack=%b required 1", held);
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0; dbus_r_data_i = '0;
      @(posedge clk); #1;
      n_tests++;
      if (dbus_req_o !== 1'b0 || ack_o !== 1'b0 || bus_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_done: req=%b ack=%b err=%b required 0/0/0", dbus_req_o, ack_o, bus_err_o);
      end
      st_req_i = 1'b1; st_ops_i = 2'd3; addr_i = 32'h0000_5004; w_data_i = 32'h0BAD_F00D;
      @(posedge clk); #1;
      st_req_i = 1'b0; flush_i = 1'b1; dbus_ack_i = 1'b1;
      #1;
      n_tests++;
      if (ack_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_with_ack: ack_o=%b required 0", ack_o);
      end
      @(posedge clk); #1;
      flush_i = 1'b0; dbus_ack_i = 1'b0;
      n_tests++;
      if (dbus_req_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_with_ack_idle: dbus_req_o=%b required 0", dbus_req_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      st_req_i = 1'b1; st_ops_i = 2'd3; addr_i = 32'h0000_7000; w_data_i = 32'hCAFE_0001;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (dbus_req_o !== 1'b0 || dbus_sel_o !== 4'h0 || dbus_w_en_o !== 1'b0 ||
          dbus_w_data_o !== 32'h0 || dbus_addr_o !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: req=%b sel=%b wen=%b wd=%h addr=%h required all 0",
                  dbus_req_o, dbus_sel_o, dbus_w_en_o, dbus_w_data_o, dbus_addr_o);
      end
      drop_reqs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      dbus_ack_i = 1'b1;
      #1;
      n_tests++;
      if (ack_o !== 1'b0 || dbus_req_o !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_stray_ack: ack=%b req=%b required 0/0", ack_o, dbus_req_o);
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0;
   endtask

   task automatic test_random();
      int mask, win, op, sz, wait_n, lat, acks;
      logic [31:0] a, wd, awd, rbus, oa, owd, ord;
      logic [3:0] osel; logic owen; bit ost;
      for (int t = 0; t < 60; t++) begin
         mask = int'($urandom_range(1, 15));
         win = 3;
         while (((mask >> win) & 1) == 0) win--;
         ld_ops_i = 3'($urandom_range(1, 5));
         st_ops_i = 2'($urandom_range(1, 3));
         op = (win == 0) ? int'(ld_ops_i) : int'(st_ops_i);
         sz = ref_size(win, op);
         a = $urandom; wd = $urandom; awd = $urandom; rbus = $urandom;
         wait_n = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) a = a - (a % sz);
         ld_req_i = mask[0]; st_req_i = mask[1]; amo_ld_req_i = mask[2]; amo_st_req_i = mask[3];
         addr_i = a; w_data_i = wd; amo_w_data_i = awd;
         #1;
         if ((a % sz) != 0) begin
            n_tests++;
            if (misalign_o !== 1'b1) begin
               n_fail++; $display("FAIL rnd%0d misalign: got %b required 1 (kind %0d op %0d addr %h)",
                                  t, misalign_o, win, op, a);
            end
            @(posedge clk); #1;
            n_tests++;
            if (dbus_req_o !== 1'b0 || ack_o !== 1'b0) begin
               n_fail++; $display("FAIL rnd%0d misalign_quiet: req=%b ack=%b required 0/0", t, dbus_req_o, ack_o);
            end
            drop_reqs();
            @(posedge clk); #1;
         end else begin
            n_tests++;
            if (misalign_o !== 1'b0) begin
               n_fail++; $display("FAIL rnd%0d aligned: misalign_o=%b required 0", t, misalign_o);
            end
            run_xfer(wait_n, rbus, lat, osel, oa, owd, owen, ord, acks, ost);
            drop_reqs();
            n_tests++;
            if (lat !== 1 || acks !== 1 || ost !== 1'b1) begin
               n_fail++; $display("FAIL rnd%0d handshake: lat=%0d acks=%0d stable=%b required 1/1/1",
                                  t, lat, acks, ost);
            end
            n_tests++;
            if (osel !== ref_sel(sz, a) || oa !== (a - (a % 4)) || owen !== win[0]) begin
               n_fail++; $display("FAIL rnd%0d bus: sel=%b addr=%h wen=%b required %b/%h/%b",
                                  t, osel, oa, owen, ref_sel(sz, a), a - (a % 4), win[0]);
            end
            n_tests++;
            if (win[0] && owd !== ((win == 3) ? awd : ref_wdata(sz, wd))) begin
               n_fail++; $display("FAIL rnd%0d wdata: got %h required %h", t, owd,
                                  (win == 3) ? awd : ref_wdata(sz, wd));
            end else if (!win[0] && ord !== ref_rdata(win, op, a, rbus)) begin
               n_fail++; $display("FAIL rnd%0d rdata: got %h required %h (op %0d addr %h bus %h)",
                                  t, ord, ref_rdata(win, op, a, rbus), op, a, rbus);
            end
            @(posedge clk); #1;
            n_tests++;
            if (dbus_req_o !== 1'b0) begin
               n_fail++; $display("FAIL rnd%0d idle_after: dbus_req_o=%b required 0", t, dbus_req_o);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int k;
      bit main_err;
      reset_dut();
      ld_req_i = 1'b1; ld_ops_i = 3'd3; addr_i = 32'h0000_6000;
      @(posedge clk); #1;
      n_tests++;
      if (to_req !== 1'b1) begin
         n_fail++; $display("FAIL to_issue: dbus_req_o=%b required 1", to_req);
      end
      k = 0; main_err = 1'b0;
      while (k < 20) begin
         @(posedge clk); #1;
         k++;
         if (bus_err_o !== 1'b0) main_err = 1'b1;
         if (to_err === 1'b1) break;
      end
      n_tests++;
      if (k !== 4 || to_req !== 1'b0) begin
         n_fail++; $display("FAIL to_pulse: err after %0d cycles req=%b required 4/0", k, to_req);
      end
      ld_req_i = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (to_err !== 1'b0 || to_req !== 1'b0 || dbus_req_o !== 1'b1 || main_err !== 1'b0) begin
         n_fail++;
         $display("FAIL to_after: err=%b req=%b main_req=%b main_err=%b required 0/0/1/0",
                  to_err, to_req, dbus_req_o, main_err);
      end
      dbus_ack_i = 1'b1; dbus_r_data_i = 32'h0000_0042;
      #1;
      n_tests++;
      if (to_ack !== 1'b0 || ack_o !== 1'b1 || r_data_o !== 32'h42) begin
         n_fail++; $display("FAIL to_stray_ack: to_ack=%b main_ack=%b main_rd=%h required 0/1/00000042",
                            to_ack, ack_o, r_data_o);
      end
      @(posedge clk); #1;
      dbus_ack_i = 1'b0; dbus_r_data_i = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_lb();
      test_sh();
      test_amo();
      test_misalign();
      test_flush();
      test_reset_mid();
      test_random();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
